fetch_prefetch_buffer: RTL

- Instruction prefetch stage directly upstream of static_branch_predict.
- Issues word fetches to instruction memory over a req/gnt/rvalid handshake and buffers responses with their PCs in an in-order FIFO.
- Presents the FIFO head as fetch_rdata_o/fetch_pc_o/fetch_valid_o.
- Redirects fetch on execute-stage branches and on taken predictions returned by the predictor.

---
 rtl/fetch_prefetch_buffer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_buffer.sv
// Word prefetcher: req/gnt/rvalid fetch into a PC-tagged in-order FIFO.
// Redirects on execute branches and on taken predictions for the head.
module fetch_prefetch_buffer #(
   parameter int unsigned DEPTH     = 3,
   parameter int unsigned MAX_OUT   = 2,
   parameter logic [31:0] BOOT_ADDR = 32'h0000_1000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_i,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   input  logic        branch_i,
   input  logic [31:0] branch_addr_i,
   input  logic        predict_taken_i,
   input  logic [31:0] predict_pc_i,
   output logic        fetch_valid_o,
   output logic [31:0] fetch_rdata_o,
   output logic [31:0] fetch_pc_o,
   input  logic        fetch_ready_i,
   output logic        busy_o
);

   localparam int unsigned FPW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned FCW = $clog2(DEPTH + 1);
   localparam int unsigned QPW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int unsigned OCW = $clog2(MAX_OUT + 1);

   logic [31:0]  fetch_addr_q, addr_d;
   logic [OCW-1:0] out_q, out_d;
   logic [OCW-1:0] discard_q, discard_d;
   logic         busy_q, busy_d;

   logic [FCW-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [FPW-1:0] fifo_rd_q, fifo_wr_q;
   logic [31:0]  fifo_data_q [DEPTH];
   logic [31:0]  fifo_pc_q   [DEPTH];

   logic [QPW-1:0] inf_rd_q, inf_wr_q;
   logic [31:0]  inf_pc_q [MAX_OUT];

   logic fifo_empty, room, gnt, rsp, drop, push, pop;
   logic pred, redirect;
   logic unused_addr_bits;

   function automatic logic [FPW-1:0] fifo_inc(logic [FPW-1:0] p);
      return (p == FPW'(DEPTH - 1)) ? '0 : p + FPW'(1);
   endfunction

   function automatic logic [QPW-1:0] inf_inc(logic [QPW-1:0] p);
      return (p == QPW'(MAX_OUT - 1)) ? '0 : p + QPW'(1);
   endfunction

   assign unused_addr_bits = ^{branch_addr_i[1:0], predict_pc_i[1:0]};

   assign fifo_empty = (fifo_cnt_q == '0);
   assign room = (32'(fifo_cnt_q) + 32'(out_q) < DEPTH)
              && (32'(out_q) < MAX_OUT);

   assign instr_req_o  = rst_ni && req_i && room;
   assign instr_addr_o = fetch_addr_q;

   assign fetch_valid_o = !fifo_empty && !branch_i;
   assign fetch_rdata_o = fifo_empty ? '0 : fifo_data_q[fifo_rd_q];
   assign fetch_pc_o    = fifo_empty ? fetch_addr_q : fifo_pc_q[fifo_rd_q];
   assign busy_o        = busy_q;

   assign gnt      = instr_req_o && instr_gnt_i;
   assign rsp      = instr_rvalid_i && (out_q != '0);
   assign drop     = rsp && (discard_q != '0);
   assign push     = rsp && !drop;
   assign pop      = fetch_valid_o && fetch_ready_i;
   assign pred     = pop && predict_taken_i;
   assign redirect = branch_i || pred;

   // Next fetch address: execute redirect beats prediction beats sequential
   always_comb begin
      addr_d = fetch_addr_q;
      priority case (1'b1)
         branch_i: addr_d = {branch_addr_i[31:2], 2'b00};
         pred:     addr_d = {predict_pc_i[31:2], 2'b00};
         gnt:      addr_d = fetch_addr_q + 32'd4;
         default:  addr_d = fetch_addr_q;
      endcase
   end

   // Counter bookkeeping; a redirect turns all in-flight requests stale
   always_comb begin
      out_d      = out_q + OCW'(gnt) - OCW'(rsp);
      discard_d  = discard_q;
      fifo_cnt_d = fifo_cnt_q + FCW'(push) - FCW'(pop);
      if (redirect) begin
         discard_d  = out_d;
         fifo_cnt_d = '0;
      end else if (drop) begin
         discard_d = discard_q - OCW'(1);
      end
      busy_d = (out_d != '0) || (fifo_cnt_d != '0);
   end

   // Fetch address, counters and registered busy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_addr_q <= BOOT_ADDR;
         out_q        <= '0;
         discard_q    <= '0;
         busy_q       <= 1'b0;
      end else begin
         fetch_addr_q <= addr_d;
         out_q        <= out_d;
         discard_q    <= discard_d;
         busy_q       <= busy_d;
      end
   end

   // Instruction FIFO: push tagged responses, pop on consume, flush on redirect
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_cnt_q <= '0;
         fifo_rd_q  <= '0;
         fifo_wr_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            fifo_data_q[i] <= '0;
            fifo_pc_q[i]   <= '0;
         end
      end else begin
         fifo_cnt_q <= fifo_cnt_d;
         if (redirect) begin
            fifo_rd_q <= '0;
            fifo_wr_q <= '0;
         end else begin
            if (push) begin
               fifo_data_q[fifo_wr_q] <= instr_rdata_i;
               fifo_pc_q[fifo_wr_q]   <= inf_pc_q[inf_rd_q];
               fifo_wr_q              <= fifo_inc(fifo_wr_q);
            end
            if (pop) begin
               fifo_rd_q <= fifo_inc(fifo_rd_q);
            end
         end
      end
   end

   // In-flight PC queue: address pushed on grant, popped on response
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inf_rd_q <= '0;
         inf_wr_q <= '0;
         for (int i = 0; i < int'(MAX_OUT); i++) begin
            inf_pc_q[i] <= '0;
         end
      end else begin
         if (gnt) begin
            inf_pc_q[inf_wr_q] <= fetch_addr_q;
            inf_wr_q           <= inf_inc(inf_wr_q);
         end
         if (rsp) begin
            inf_rd_q <= inf_inc(inf_rd_q);
         end
      end
   end

endmodule
